n64_state_filter: RTL

- Downstream consumer of the controller-poll stage: takes the 32-bit reply word and its completion strobe (ctrl_clk), and brings them into the clk_4M domain.
- Validates each frame, debounces the buttons across successive polls and applies a stick deadzone.
- Tracks whether a controller is present, and queues button-change events in a small FIFO with a valid/ready handshake for the application logic (LEDs, UART, game logic).

---
 rtl/n64_state_filter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/n64_state_filter.sv
// n64_state_filter: brings the controller-poll reply word into the clk_4M
// domain, validates and debounces each frame, applies a stick deadzone,
// tracks controller presence and queues button-change events in a small
// valid/ready FIFO.
module n64_state_filter #(
  parameter int STABLE_FRAMES = 2,
  parameter int DEADZONE      = 8,
  parameter int TIMEOUT       = 16384,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk_4M,
  input  logic        rst_n,
  input  logic [31:0] ctrl_state,
  input  logic        ctrl_clk,
  output logic [15:0] buttons,
  output logic [7:0]  stick_x,
  output logic [7:0]  stick_y,
  output logic        present,
  output logic [31:0] ev_data,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count,
  output logic [7:0]  drop_count
);

  localparam int         WD_W       = $clog2(TIMEOUT + 1);
  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam int         CW         = AW + 1;
  localparam logic [3:0] STABLE_RUN = 4'(STABLE_FRAMES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_HOLD = WD_W'(TIMEOUT);

  // Counters stick at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Small stick deflections read as centred; -128 has magnitude 128 and
  // therefore always passes.
  function automatic logic signed [7:0] apply_deadzone(input logic signed [7:0] v);
    int mag;
    mag = (v < 0) ? -int'(v) : int'(v);
    return (mag <= DEADZONE) ? 8'sd0 : v;
  endfunction

  logic        sync1, sync2, sync_prev;
  logic        edge_det;
  logic        vld_p0;
  logic        vld_p1;
  logic [31:0] frame_p1;
  logic [31:0] cand;
  logic [3:0]  run;
  logic [3:0]  run_nxt;
  logic        frame_ok, frame_bad, commit_p0;
  logic [WD_W-1:0] wd_cnt;
  logic        timeout_hit;

  logic [15:0]        new_btn;
  logic signed [7:0]  new_x, new_y;
  logic               push_req;
  logic [31:0]        push_data;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push, drop;

  // ---- strobe synchroniser / edge detect ----
  assign edge_det = sync2 & ~sync_prev;

  // Two-flop synchroniser on the strobe plus the previous-value flop; the
  // cycle after an edge is the capture cycle (vld_p0).
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      sync1     <= ctrl_clk;
      sync2     <= sync1;
      sync_prev <= sync2;
      vld_p0    <= edge_det;
    end
  end

  // ---- p0: capture, validate, debounce ----
  assign frame_ok  = vld_p0 & ~ctrl_state[22];
  assign frame_bad = vld_p0 &  ctrl_state[22];

  // Run length of identical valid frames, saturating at the commit threshold.
  always_comb begin
    run_nxt = 4'd1;
    if (ctrl_state == cand)
      run_nxt = (run >= STABLE_RUN) ? STABLE_RUN : run + 4'd1;
  end

  assign commit_p0 = frame_ok && (run_nxt == STABLE_RUN);

  // Candidate word and run count; a timeout restarts the run so presence
  // needs a fresh stable sequence.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= 32'h0;
      run    <= 4'd0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= commit_p0;
      if (frame_ok) begin
        cand <= ctrl_state;
        run  <= run_nxt;
      end else if (timeout_hit) begin
        run <= 4'd0;
      end
    end
  end

  // Frame carried to the commit stage; only meaningful alongside vld_p1.
  always_ff @(posedge clk_4M) begin
    if (vld_p0)
      frame_p1 <= ctrl_state;
  end

  // Frame and error statistics.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 16'h0;
      err_count   <= 8'h0;
    end else begin
      if (frame_ok)
        frame_count <= frame_count + 16'd1;
      if (frame_bad)
        err_count <= sat_inc8(err_count);
    end
  end

  // ---- watchdog ----
  assign timeout_hit = (wd_cnt == WD_LAST) && !edge_det;

  // Cycles since the last strobe edge; parks at TIMEOUT once expired.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n)
      wd_cnt <= '0;
    else if (edge_det)
      wd_cnt <= '0;
    else if (timeout_hit)
      wd_cnt <= WD_HOLD;
    else if (wd_cnt != WD_HOLD)
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  // ---- p1: commit and event generation ----
  assign new_btn = {frame_p1[31:23], 1'b0, frame_p1[21:16]};
  assign new_x   = apply_deadzone($signed(frame_p1[15:8]));
  assign new_y   = apply_deadzone($signed(frame_p1[7:0]));

  // A commit that changes the buttons, or a timeout while anything is held,
  // produces one event.
  always_comb begin
    push_req  = 1'b0;
    push_data = 32'h0;
    if (vld_p1) begin
      if (new_btn != buttons) begin
        push_req  = 1'b1;
        push_data = {new_btn, new_btn ^ buttons};
      end
    end else if (timeout_hit && (buttons != 16'h0)) begin
      push_req  = 1'b1;
      push_data = {16'h0, buttons};
    end
  end

  // Committed controller state.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      buttons <= 16'h0;
      stick_x <= 8'h0;
      stick_y <= 8'h0;
      present <= 1'b0;
    end else if (vld_p1) begin
      buttons <= new_btn;
      stick_x <= new_x;
      stick_y <= new_y;
      present <= 1'b1;
    end else if (timeout_hit) begin
      buttons <= 16'h0;
      stick_x <= 8'h0;
      stick_y <= 8'h0;
      present <= 1'b0;
    end
  end

  // ---- event FIFO ----
  assign full     = (count == CW'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid & ev_ready;
  assign do_push  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ev_data  = mem[rd_ptr];

  // Pointers, occupancy and drop statistic; a pop frees space for a
  // same-cycle push even when full.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= 8'h0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)
        count <= count + CW'(1);
      else if (!do_push && pop)
        count <= count - CW'(1);
      if (drop)
        drop_count <= sat_inc8(drop_count);
    end
  end

  // Event storage; cleared so the head reads 0 out of reset.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 32'h0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule
